// File: rtl/seq_div_16_8_if.sv
// Valid/ready stream bundle for seq_div_16_8: operand channel in, result channel out.
interface seq_div_16_8_if #(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_A-1:0] dividend;
  logic [WIDTH_B-1:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_A-1:0] quotient;
  logic [WIDTH_B-1:0] remainder;
  logic               div_zero;

  // Stimulus / consumer side.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_div_16_8.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor bypasses the iteration
// loop and presents the all-ones quotient the cycle after accept.
module seq_div_16_8 #(
  parameter int unsigned WIDTH_A = 16,
  parameter int unsigned WIDTH_B = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_div_16_8_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH_A + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q;
  logic [WIDTH_A-1:0] q_q;
  logic [WIDTH_B-1:0] d_q;
  // The partial remainder is always below the divisor, so its top bit is
  // carried only transiently in the trial value t.
  logic [WIDTH_B-1:0] r_q;
  logic [CntW-1:0]    cnt_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH_A-1:0] quotient_q;
  logic [WIDTH_B-1:0] remainder_q;
  logic               div_zero_q;

  logic [WIDTH_B:0]   t;
  logic               ge;
  logic [WIDTH_B-1:0] r_nxt;
  logic [WIDTH_A-1:0] q_nxt;

  // One restoring iteration: shift in the next dividend bit and trial-subtract.
  always_comb begin
    t     = {r_q, q_q[WIDTH_A-1]};
    ge    = (t >= {1'b0, d_q});
    // The true difference fits in WIDTH_B bits whenever ge holds.
    r_nxt = ge ? (t[WIDTH_B-1:0] - d_q) : t[WIDTH_B-1:0];
    q_nxt = {q_q[WIDTH_A-2:0], ge};
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            q_q        <= bus.dividend;
            d_q        <= bus.divisor;
            r_q        <= '0;
            cnt_q      <= CntW'(WIDTH_A);
            div_zero_q <= (bus.divisor == '0);
            in_ready_q <= 1'b0;
            state_q    <= StBusy;
`ifdef DIV_ZERO_FAST_EN
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend[WIDTH_B-1:0];
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
`endif
          end
        end
        StBusy: begin
          q_q   <= q_nxt;
          r_q   <= r_nxt;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            quotient_q  <= q_nxt;
            remainder_q <= r_nxt;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div_16_8.sv
// Bench for seq_div_16_8: directed cases, backpressure, mid-run reset and a
// randomized multiply/divide round trip, checked against a scoreboard queue.
module tb_seq_div_16_8;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZeroLat = 0;
`else
  localparam int ZeroLat = 16;
`endif

  seq_div_16_8_if #(.WIDTH_A(16), .WIDTH_B(8)) bus ();

  seq_div_16_8 #(.WIDTH_A(16), .WIDTH_B(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 8'd0) begin
      e.q  = 16'hFFFF;
      e.r  = a[7:0];
      e.dz = 1'b1;
    end else begin
      e.q  = a / {8'd0, b};
      e.r  = 8'(a % {8'd0, b});
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected result and compare it to the DUT outputs.
  task automatic check_result(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL %s_sb: observed result with empty scoreboard, expected pending entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(bus.quotient), 32'(e.q));
      chk({tag, "_r"}, 32'(bus.remainder), 32'(e.r));
      chk({tag, "_dz"}, 32'(bus.div_zero), 32'(e.dz));
    end
  endtask

  // One directed operation: accept, measure latency (edges after the accept
  // edge until out_valid), check result, optional backpressure, then release.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input int exp_lat, input int bp);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.out_ready = 1'b0;
    e = model(a, b);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_result(tag);
    if (bp > 0) begin
      // Offered operands while busy must be ignored, not buffered.
      bus.in_valid = 1'b1;
      bus.dividend = 16'h5555;
      bus.divisor  = 8'h03;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_bp_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_bp_q"}, 32'(bus.quotient), 32'(e.q));
        chk({tag, "_bp_r"}, 32'(bus.remainder), 32'(e.r));
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   sent;
    int   got;
    int   cyc;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op("ffff_ff", 16'hFFFF, 8'hFF, 16, 0);
    run_op("1000_7", 16'd1000, 8'd7, 16, 0);
    run_op("5_9", 16'd5, 8'd9, 16, 0);
    run_op("div0", 16'h1234, 8'h00, ZeroLat, 0);
    run_op("bp", 16'hBEEF, 8'h2A, 16, 10);

    // Asynchronous reset after eight iterations of 0xABCD / 0x13.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 16'hABCD;
    bus.divisor  = 8'h13;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_q", 32'(bus.quotient), 32'd0);
    chk("arst_r", 32'(bus.remainder), 32'd0);
    chk("arst_dz", 32'(bus.div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 16'hABCD, 8'h13, 16, 0);

    // Round trip: dividend = a*b, divisor = b, random valid/ready gaps.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 2000 && cyc < 80000) begin
      logic [7:0] a;
      logic [7:0] b;
      @(negedge clk);
      cyc++;
      a = 8'($urandom_range(255, 1));
      b = 8'($urandom_range(255, 1));
      bus.in_valid  = (sent < 2000) && ($urandom_range(3, 0) != 0);
      bus.dividend  = {8'd0, a} * {8'd0, b};
      bus.divisor   = b;
      bus.out_ready = ($urandom_range(3, 0) != 0);
      if (bus.in_valid && bus.in_ready) begin
        e.q  = {8'd0, a};
        e.r  = 8'd0;
        e.dz = 1'b0;
        sb.push_back(e);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        check_result("rt");
        got++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("rt_count", 32'(got), 32'd2000);
    chk("rt_sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
